// File: rtl/wb_pkg.sv
// ---------------------------------------------------------------------------
// wb_pkg
// Shared types and default sizes for the eviction write buffer.
//   wb_state_t : drain state machine states (WB_IDLE, WB_BUSY)
//   wb_entry_t : one buffered eviction {addr, data} at the default widths
//   WB_*       : default address/data widths and buffer depth
// ---------------------------------------------------------------------------
package wb_pkg;

    localparam int WB_ADDRSIZE = 32;
    localparam int WB_DATASIZE = 32;
    localparam int WB_DEPTH    = 4;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_BUSY = 1'b1
    } wb_state_t;

    typedef struct packed {
        logic [WB_ADDRSIZE-1:0] addr;
        logic [WB_DATASIZE-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// ---------------------------------------------------------------------------
// wb_fifo
// Circular entry store for the eviction write buffer.
// Ports:
//   clk, rst_n             : clock, asynchronous active-low reset
//   push, push_addr/data   : append an entry at the tail
//   pop                    : retire the head entry
//   upd, upd_pos, upd_data : overwrite the data of the entry upd_pos places
//                            behind the head (used for coalescing)
//   head_addr, head_data   : oldest entry
//   ent_addr, ent_data     : all entries flattened in age order (slot 0 = head)
//   ent_valid              : per-slot valid mask matching ent_addr/ent_data
//   full, empty, count     : occupancy, derived from the registered count
// ---------------------------------------------------------------------------
module wb_fifo
    import wb_pkg::*;
#(
    parameter int ADDRSIZE = WB_ADDRSIZE,
    parameter int DATASIZE = WB_DATASIZE,
    parameter int DEPTH    = WB_DEPTH,
    parameter int PTRSIZE  = $clog2(DEPTH)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [ADDRSIZE-1:0]          push_addr,
    input  logic [DATASIZE-1:0]          push_data,
    input  logic                         pop,
    input  logic                         upd,
    input  logic [PTRSIZE-1:0]           upd_pos,
    input  logic [DATASIZE-1:0]          upd_data,
    output logic [ADDRSIZE-1:0]          head_addr,
    output logic [DATASIZE-1:0]          head_data,
    output logic [DEPTH*ADDRSIZE-1:0]    ent_addr,
    output logic [DEPTH*DATASIZE-1:0]    ent_data,
    output logic [DEPTH-1:0]             ent_valid,
    output logic                         full,
    output logic                         empty,
    output logic [PTRSIZE:0]             count
);

    logic [ADDRSIZE-1:0] addr_mem [DEPTH];
    logic [DATASIZE-1:0] data_mem [DEPTH];
    logic [PTRSIZE-1:0]  wr_ptr;
    logic [PTRSIZE-1:0]  rd_ptr;
    logic                do_push;
    logic                do_pop;
    logic [PTRSIZE-1:0]  idx;

    // Occupancy comes from the count so a full buffer and an empty one
    // are never confused when the pointers coincide.
    assign full    = (count == (PTRSIZE+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTRSIZE'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTRSIZE'(1);
            count <= count + (PTRSIZE+1)'(do_push) - (PTRSIZE+1)'(do_pop);
        end
    end

    // Storage is not reset: slots outside the valid window are never observed.
    always_ff @(posedge clk) begin
        if (do_push) begin
            addr_mem[wr_ptr] <= push_addr;
            data_mem[wr_ptr] <= push_data;
        end
        if (upd) begin
            data_mem[rd_ptr + upd_pos] <= upd_data;
        end
    end

    assign head_addr = addr_mem[rd_ptr];
    assign head_data = data_mem[rd_ptr];

    // Present entries oldest-first so the lookup can let newer slots win.
    always_comb begin
        ent_addr  = '0;
        ent_data  = '0;
        ent_valid = '0;
        idx       = '0;
        for (int k = 0; k < DEPTH; k++) begin
            idx = rd_ptr + PTRSIZE'(k);
            ent_addr[k*ADDRSIZE +: ADDRSIZE] = addr_mem[idx];
            ent_data[k*DATASIZE +: DATASIZE] = data_mem[idx];
            ent_valid[k] = ((PTRSIZE+1)'(k) < count);
        end
    end

endmodule

// File: rtl/evict_write_buffer.sv
// ---------------------------------------------------------------------------
// evict_write_buffer
// Queues dirty words evicted by the data cache and drains them to memory
// with a req/ack handshake; offers a combinational lookup so a miss can be
// served from a pending eviction.
// Ports:
//   clk, rst_n                  : clock, asynchronous active-low reset
//   evict, evaddr, evdata       : eviction from the cache
//   ev_ready                    : eviction can be accepted (= !full)
//   lookup_addr                 : miss address to search for
//   lookup_hit, lookup_data     : newest pending match (data 0 on no hit)
//   mem_req, mem_addr, mem_wdata: write request to memory (head entry)
//   mem_ack                     : memory accepted the write
//   empty, full, count          : buffer occupancy
// Build option: EVICT_COALESCE_EN merges an eviction into a pending entry
// with the same address instead of appending a duplicate.
// ---------------------------------------------------------------------------
module evict_write_buffer
    import wb_pkg::*;
#(
    parameter int ADDRSIZE = WB_ADDRSIZE,
    parameter int DATASIZE = WB_DATASIZE,
    parameter int DEPTH    = WB_DEPTH,
    parameter int PTRSIZE  = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                evict,
    input  logic [ADDRSIZE-1:0] evaddr,
    input  logic [DATASIZE-1:0] evdata,
    output logic                ev_ready,
    input  logic [ADDRSIZE-1:0] lookup_addr,
    output logic                lookup_hit,
    output logic [DATASIZE-1:0] lookup_data,
    output logic                mem_req,
    output logic [ADDRSIZE-1:0] mem_addr,
    output logic [DATASIZE-1:0] mem_wdata,
    input  logic                mem_ack,
    output logic                empty,
    output logic                full,
    output logic [PTRSIZE:0]    count
);

    wb_state_t                  state;
    wb_state_t                  state_next;
    logic                       load_req;
    logic                       pop;
    logic                       accept;
    logic                       push;
    logic                       upd;
    logic                       co_hit;
    logic [PTRSIZE-1:0]         co_pos;
    logic [ADDRSIZE-1:0]        head_addr;
    logic [DATASIZE-1:0]        head_data;
    logic [DEPTH*ADDRSIZE-1:0]  ent_addr;
    logic [DEPTH*DATASIZE-1:0]  ent_data;
    logic [DEPTH-1:0]           ent_valid;

    wb_fifo #(
        .ADDRSIZE (ADDRSIZE),
        .DATASIZE (DATASIZE),
        .DEPTH    (DEPTH),
        .PTRSIZE  (PTRSIZE)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_addr (evaddr),
        .push_data (evdata),
        .pop       (pop),
        .upd       (upd),
        .upd_pos   (co_pos),
        .upd_data  (evdata),
        .head_addr (head_addr),
        .head_data (head_data),
        .ent_addr  (ent_addr),
        .ent_data  (ent_data),
        .ent_valid (ent_valid),
        .full      (full),
        .empty     (empty),
        .count     (count)
    );

    // Acceptance looks only at the pre-edge full flag, so a pop on the same
    // edge never frees room for an eviction.
    assign ev_ready = !full;
    assign accept   = evict && !full;
    assign push     = accept && !co_hit;
    assign upd      = accept && co_hit;

`ifdef EVICT_COALESCE_EN
    // Newest matching entry wins; the head being written to memory is left
    // alone so mem_wdata cannot change under an outstanding request.
    always_comb begin
        co_hit = 1'b0;
        co_pos = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && ent_addr[k*ADDRSIZE +: ADDRSIZE] == evaddr &&
                !(k == 0 && state == WB_BUSY)) begin
                co_hit = 1'b1;
                co_pos = PTRSIZE'(k);
            end
        end
    end
`else
    assign co_hit = 1'b0;
    assign co_pos = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= WB_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // IDLE launches a request as soon as anything is queued; BUSY waits
    // for the ack, pops, and returns to IDLE (one bubble cycle per entry).
    always_comb begin
        state_next = state;
        load_req   = 1'b0;
        pop        = 1'b0;
        case (state)
            WB_IDLE: begin
                if (!empty) begin
                    state_next = WB_BUSY;
                    load_req   = 1'b1;
                end
            end
            WB_BUSY: begin
                if (mem_ack) begin
                    state_next = WB_IDLE;
                    pop        = 1'b1;
                end
            end
            default: state_next = WB_IDLE;
        endcase
    end

    // mem_req follows the state register so reset removes it immediately.
    assign mem_req = (state == WB_BUSY);

    // When an eviction coalesces into the head on the same edge the request
    // is launched, forward the new data so the stale word is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else if (load_req) begin
            mem_addr  <= head_addr;
            mem_wdata <= (upd && co_pos == '0) ? evdata : head_data;
        end
    end

    // Later slots are newer, so the last match in the scan is the newest.
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_valid[k] && ent_addr[k*ADDRSIZE +: ADDRSIZE] == lookup_addr) begin
                lookup_hit  = 1'b1;
                lookup_data = ent_data[k*DATASIZE +: DATASIZE];
            end
        end
    end

endmodule

// File: tb/tb_evict_write_buffer.sv
// ---------------------------------------------------------------------------
// tb_evict_write_buffer
// Directed and random stimulus for evict_write_buffer, checked against a
// queue-based reference model of the buffer and its memory request.
// ---------------------------------------------------------------------------
module tb_evict_write_buffer;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        evict = 1'b0;
    logic [31:0] evaddr = '0;
    logic [31:0] evdata = '0;
    logic        ev_ready;
    logic [31:0] lookup_addr = '0;
    logic        lookup_hit;
    logic [31:0] lookup_data;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic        empty;
    logic        full;
    logic [2:0]  count;

    int tests  = 0;
    int failed = 0;

    // Reference model: pending entries oldest-first, plus the request view.
    wb_entry_t   q[$];
    bit          busy = 1'b0;
    logic [31:0] cur_addr = '0;
    logic [31:0] cur_data = '0;

    always #5 clk = ~clk;

    evict_write_buffer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .evict       (evict),
        .evaddr      (evaddr),
        .evdata      (evdata),
        .ev_ready    (ev_ready),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_ack     (mem_ack),
        .empty       (empty),
        .full        (full),
        .count       (count)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        q.delete();
        busy     = 1'b0;
        cur_addr = '0;
        cur_data = '0;
    endfunction

    // One clock edge of the buffer as seen from outside.
    function automatic void model_clock(input bit ev, input logic [31:0] a,
                                        input logic [31:0] d, input bit ack);
        bit accept  = ev && (q.size() < DEPTH);
        bit go_busy = !busy && (q.size() > 0);
        bit do_pop  = busy && ack;
        bit merged  = 1'b0;
`ifdef EVICT_COALESCE_EN
        if (accept) begin
            for (int i = q.size() - 1; i >= 0 && !merged; i--) begin
                if (q[i].addr == a && !(i == 0 && busy)) begin
                    q[i].data = d;
                    merged    = 1'b1;
                end
            end
        end
`endif
        if (go_busy) begin
            busy     = 1'b1;
            cur_addr = q[0].addr;
            cur_data = q[0].data;
        end else if (do_pop) begin
            void'(q.pop_front());
            busy = 1'b0;
        end
        if (accept && !merged) q.push_back('{addr: a, data: d});
    endfunction

    function automatic void model_lookup(input logic [31:0] a, output bit hit,
                                         output logic [31:0] data);
        hit  = 1'b0;
        data = '0;
        foreach (q[i]) begin
            if (q[i].addr == a) begin
                hit  = 1'b1;
                data = q[i].data;
            end
        end
    endfunction

    task automatic check_output(input string tag);
        bit          exp_hit;
        logic [31:0] exp_data;
        model_lookup(lookup_addr, exp_hit, exp_data);
        chk({tag, ".count"},     64'(count),       64'(q.size()));
        chk({tag, ".empty"},     64'(empty),       64'(q.size() == 0));
        chk({tag, ".full"},      64'(full),        64'(q.size() == DEPTH));
        chk({tag, ".ev_ready"},  64'(ev_ready),    64'(q.size() != DEPTH));
        chk({tag, ".mem_req"},   64'(mem_req),     64'(busy));
        chk({tag, ".mem_addr"},  64'(mem_addr),    64'(cur_addr));
        chk({tag, ".mem_wdata"}, 64'(mem_wdata),   64'(cur_data));
        chk({tag, ".hit"},       64'(lookup_hit),  64'(exp_hit));
        chk({tag, ".ldata"},     64'(lookup_data), 64'(exp_data));
    endtask

    // Drive one cycle of inputs from a negedge, clock it, check at the next negedge.
    task automatic apply_stimulus(input bit ev, input logic [31:0] a, input logic [31:0] d,
                                  input bit ack, input logic [31:0] la, input string tag);
        evict       = ev;
        evaddr      = a;
        evdata      = d;
        mem_ack     = ack;
        lookup_addr = la;
        @(posedge clk);
        model_clock(ev, a, d, ack);
        @(negedge clk);
        check_output(tag);
    endtask

    task automatic drain_all(input string tag);
        for (int i = 0; i < 40 && q.size() > 0; i++) apply_stimulus(1'b0, '0, '0, 1'b1, '0, tag);
        chk({tag, ".drained"}, 64'(count), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] order[$];
        logic [31:0] exp_order[4];

        // Reset state, with rst_n asserted from time zero.
        model_reset();
        @(negedge clk);
        check_output("reset");
        chk("reset.empty_const", 64'(empty), 64'd1);
        chk("reset.req_const",   64'(mem_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single eviction, request held while ack is low.
        apply_stimulus(1'b1, 32'd19, 32'd20, 1'b0, 32'd19, "single.enq");
        chk("single.count1", 64'(count), 64'd1);
        apply_stimulus(1'b0, '0, '0, 1'b0, '0, "single.req");
        chk("single.req1", 64'(mem_req), 64'd1);
        chk("single.addr", 64'(mem_addr), 64'd19);
        chk("single.data", 64'(mem_wdata), 64'd20);
        for (int i = 0; i < 3; i++) apply_stimulus(1'b0, '0, '0, 1'b0, '0, "single.hold");
        chk("single.hold_addr", 64'(mem_addr), 64'd19);
        apply_stimulus(1'b0, '0, '0, 1'b1, '0, "single.ack");
        chk("single.count0", 64'(count), 64'd0);
        chk("single.req0", 64'(mem_req), 64'd0);

        // Fill with ack stalled; fifth eviction must be refused.
        for (int i = 1; i <= 4; i++)
            apply_stimulus(1'b1, 32'(4 * i), 32'(100 + i), 1'b0, 32'(4 * i), "fill.enq");
        chk("fill.full", 64'(full), 64'd1);
        chk("fill.ready", 64'(ev_ready), 64'd0);
        apply_stimulus(1'b1, 32'd20, 32'd200, 1'b0, 32'd20, "fill.reject");
        chk("fill.count4", 64'(count), 64'd4);
        chk("fill.no_hit20", 64'(lookup_hit), 64'd0);
        for (int i = 0; i < 40 && q.size() > 0; i++) begin
            if (mem_req) order.push_back(mem_addr);
            apply_stimulus(1'b0, '0, '0, 1'b1, '0, "fill.drain");
        end
        exp_order = '{32'd4, 32'd8, 32'd12, 32'd16};
        chk("fill.order_len", 64'(order.size()), 64'd4);
        for (int i = 0; i < 4 && i < order.size(); i++)
            chk("fill.order", 64'(order[i]), 64'(exp_order[i]));

        // Forwarding from the newest matching entry.
        apply_stimulus(1'b1, 32'd4, 32'd5, 1'b0, 32'd4, "fwd.enq1");
        apply_stimulus(1'b1, 32'd4, 32'd11, 1'b0, 32'd4, "fwd.enq2");
        chk("fwd.hit", 64'(lookup_hit), 64'd1);
        chk("fwd.data", 64'(lookup_data), 64'd11);
`ifdef EVICT_COALESCE_EN
        chk("fwd.count", 64'(count), 64'd1);
`else
        chk("fwd.count", 64'(count), 64'd2);
`endif
        apply_stimulus(1'b0, '0, '0, 1'b0, 32'd8, "fwd.miss");
        chk("fwd.miss_hit", 64'(lookup_hit), 64'd0);
        chk("fwd.miss_data", 64'(lookup_data), 64'd0);
        drain_all("fwd");

        // Duplicate address arriving while the head is already being written.
        apply_stimulus(1'b1, 32'd8, 32'd11, 1'b0, 32'd8, "busy.enq1");
        apply_stimulus(1'b0, '0, '0, 1'b0, 32'd8, "busy.launch");
        apply_stimulus(1'b1, 32'd8, 32'd5, 1'b0, 32'd8, "busy.enq2");
        chk("busy.count2", 64'(count), 64'd2);
        chk("busy.wdata", 64'(mem_wdata), 64'd11);
        drain_all("busy");

        // Reset in the middle of a drain.
        for (int i = 0; i < 3; i++)
            apply_stimulus(1'b1, 32'(64 + 4 * i), 32'(i + 7), 1'b0, 32'd64, "rst.enq");
        chk("rst.req_before", 64'(mem_req), 64'd1);
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("rst.req_async", 64'(mem_req), 64'd0);
        chk("rst.count_async", 64'(count), 64'd0);
        chk("rst.empty_async", 64'(empty), 64'd1);
        chk("rst.hit_async", 64'(lookup_hit), 64'd0);
        chk("rst.addr_async", 64'(mem_addr), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        apply_stimulus(1'b0, '0, '0, 1'b1, 32'd64, "rst.late_ack");
        chk("rst.late_ack_req", 64'(mem_req), 64'd0);

        // Random traffic over a small address set to provoke duplicates.
        for (int i = 0; i < 400; i++) begin
            apply_stimulus(($urandom_range(0, 9) < 6), 32'($urandom_range(0, 7) * 4), $urandom,
                           ($urandom_range(0, 9) < 4), 32'($urandom_range(0, 8) * 4), "rand");
        end
        drain_all("final");

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/evict_write_buffer.md
Name: evict_write_buffer

Overview:
- Sits directly downstream of the data cache. Accepts evicted (dirty) words on the cache's evict/evaddr/evdata outputs and queues them in a small FIFO.
- Drains the queue to main memory through a req/ack write handshake, so the cache never stalls on a memory write unless the buffer is full.
- Provides a combinational lookup port so a cache miss can forward data from a pending eviction instead of reading stale memory.

Parameters:
- ADDRSIZE, 32, address width (matches cache).
- DATASIZE, 32, data word width (matches cache).
- DEPTH, 4, number of buffer entries; power of two, minimum 2.
- PTRSIZE, 2, log2(DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- evict  in  1  cache presents an eviction this cycle.
- evaddr  in  ADDRSIZE  eviction address.
- evdata  in  DATASIZE  eviction data.
- ev_ready  out  1  buffer can accept an eviction (= !full).
- lookup_addr  in  ADDRSIZE  miss address from cache.
- lookup_hit  out  1  a pending entry matches lookup_addr.
- lookup_data  out  DATASIZE  data of the newest matching entry; 0 when no hit.
- mem_req  out  1  write request to memory.
- mem_addr  out  ADDRSIZE  write address (head entry).
- mem_wdata  out  DATASIZE  write data (head entry).
- mem_ack  in  1  memory accepted the write; valid only while mem_req=1.
- empty  out  1  no entries.
- full  out  1  count == DEPTH.
- count  out  PTRSIZE+1  number of valid entries.

Behaviour:
- Reset (async, rst_n=0):
  - wr_ptr, rd_ptr and count cleared; FSM goes to IDLE.
  - mem_req=0, mem_addr=0, mem_wdata=0, empty=1, full=0, ev_ready=1, lookup_hit=0, lookup_data=0.
  - Queued entries are discarded. Reset mid-drain drops mem_req immediately, with no ack wait.
- Enqueue: on a clk edge with evict=1 and full=0, write {evaddr, evdata} at wr_ptr, increment wr_ptr (wrap modulo DEPTH), increment count.
- Enqueue while full: evict=1 with full=1 is ignored, and no state changes. The cache must hold its eviction until ev_ready=1.
- Enqueue during a pop: evict with a simultaneous pop while full is not accepted; ev_ready is derived from the pre-edge full.
- Drain FSM, two states:
  - IDLE: if !empty, go to BUSY next edge and register mem_req=1, mem_addr/mem_wdata from the head entry.
  - BUSY: mem_req, mem_addr and mem_wdata are held stable until mem_ack=1. On the ack edge: pop the head (rd_ptr++, count--), mem_req=0, return to IDLE.
  - Minimum of 2 cycles per drained entry; a one-cycle bubble between requests.
- Enqueue and pop on the same edge: count is unchanged and both pointers advance.
- Lookup (combinational):
  - Scan all valid entries; lookup_hit=1 if any address equals lookup_addr.
  - lookup_data comes from the most recently enqueued match.
  - The head entry in BUSY is still valid for lookup until its ack edge.
- Pointer wrap: pointers are PTRSIZE bits. full/empty are derived from count, not from pointer equality.
- count is registered and never exceeds DEPTH or underflows. mem_ack in IDLE is ignored.

Optional Feature:
- Macro: EVICT_COALESCE_EN.
- Defined:
  - An accepted eviction whose evaddr matches a valid entry overwrites that entry's data in place. count and wr_ptr are unchanged.
  - Exception: the matching entry is the head while in BUSY. In that case a new entry is appended, so mem_wdata stays stable.
  - While full, an eviction that would coalesce is still rejected. ev_ready stays = !full.
- Undefined: every accepted eviction appends a new entry; duplicate addresses may coexist, and lookup returns the newest.

Decomposition:
- Package wb_pkg holds:
  - the drain state enum (WB_IDLE, WB_BUSY);
  - default ADDRSIZE/DATASIZE/DEPTH constants;
  - a packed struct wb_entry_t {addr, data}.
- One sub-module: wb_fifo. It holds the entry storage, pointers and count, exposes head entry, full/empty/count and a flat entry array for the lookup compare. The top level holds the FSM, lookup and coalesce logic.

Test Plan:
- Reset then idle: rst_n low at mid-cycle → all outputs at reset values within the same cycle; empty=1, mem_req=0.
- Single eviction: evict with evaddr=19, evdata=20 → count=1, next edge mem_req=1 with mem_addr=19, mem_wdata=20. Hold mem_ack=0 for 3 cycles → outputs stable. Ack → count=0, mem_req=0.
- Fill with ack stalled: 4 evictions to addr 4, 8, 12, 16 → full=1, ev_ready=0. A 5th evict to addr 20 is dropped. Drain order is 4, 8, 12, 16.
- Forwarding: enqueue (4,5) then (4,11), lookup_addr=4 → lookup_hit=1, lookup_data=11 (without EVICT_COALESCE_EN, count=2). lookup_addr=8 → hit=0, data=0.
- Coalesce (EVICT_COALESCE_EN): enqueue (8,11) in IDLE with mem_ack low, then (8,5) before BUSY → count=1, drained data=5. Repeat with entry already in BUSY → count=2.
- Reset mid-drain: mem_req=1 with 3 entries, assert rst_n=0 → mem_req drops async, count=0. Late mem_ack after release is ignored.
